// File: rtl/rgb_pwm_fader.sv
// Three-channel LED PWM fader: each channel ramps its duty toward the extreme its target requests.
// Latency: LED drives and settled are registered, one cycle after the pwm_cnt/duty values that produce them.
// Backpressure: none; free-running, and enable only masks the LED drives.
module rgb_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 12000,
    parameter int STEP     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic red,
    input  logic green,
    input  logic blue,
    output logic led_r_n,
    output logic led_g_n,
    output logic led_b_n,
    output logic settled
);

    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam int                  RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_WIDE = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);

    // Decoded per-channel status; it is a pure function of target and duty,
    // so there is no separate state register to keep coherent.
    typedef enum logic [1:0] {
        CH_OFF,
        CH_RISING,
        CH_ON,
        CH_FALLING
    } ch_state_t;

    // Channel index: 0 = red, 1 = green, 2 = blue.
    logic [2:0]          target;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic                ramp_tick;
    logic [PWM_BITS-1:0] duty        [3];
    logic [PWM_BITS-1:0] duty_next   [3];
    logic [PWM_BITS:0]   duty_sum    [3];
    logic [PWM_BITS-1:0] active_duty [3];
    ch_state_t           ch_state    [3];
    logic [2:0]          lit;
    logic                settled_next;

    assign target    = {blue, green, red};
    assign ramp_tick = (ramp_cnt == RAMP_LAST);

    // Free-running PWM period counter, wraps MAX -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Ramp prescaler: one ramp_tick every RAMP_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_cnt <= '0;
        end else if (ramp_tick) begin
            ramp_cnt <= '0;
        end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
        end
    end

    // Saturating duty step toward the target extreme; the sum is one bit wider so it cannot wrap.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            duty_sum[i]  = {1'b0, duty[i]} + STEP_WIDE;
            duty_next[i] = duty[i];
            if (ramp_tick) begin
                if (target[i]) begin
                    duty_next[i] = (duty_sum[i] > {1'b0, MAX}) ? MAX : duty_sum[i][PWM_BITS-1:0];
                end else begin
                    duty_next[i] = (duty[i] < STEP_N) ? '0 : duty[i] - STEP_N;
                end
            end
        end
    end

    // Channel status from target and post-update duty; settled when no channel is still moving.
    always_comb begin
        settled_next = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_state[i] = CH_OFF;
            if (target[i]) begin
                ch_state[i] = (duty_next[i] == MAX) ? CH_ON : CH_RISING;
            end else begin
                ch_state[i] = (duty_next[i] == '0) ? CH_OFF : CH_FALLING;
            end
            if ((ch_state[i] == CH_RISING) || (ch_state[i] == CH_FALLING)) begin
                settled_next = 1'b0;
            end
        end
    end

    // Working duty follows the ramp; the active copy is only refreshed at the period
    // boundary so a PWM period always uses a single duty (pre-tick value on a coincident tick).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                duty[i]        <= '0;
                active_duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                duty[i] <= duty_next[i];
                if (pwm_cnt == MAX) begin
                    active_duty[i] <= duty[i];
                end
            end
        end
    end

    // Lit compare; full-scale duty is lit for the whole period, zero duty never lights.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lit[i] = (active_duty[i] == MAX) || (pwm_cnt < active_duty[i]);
        end
    end

    // Registered active-low drives and settled flag; no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r_n <= 1'b1;
            led_g_n <= 1'b1;
            led_b_n <= 1'b1;
            settled <= 1'b1;
        end else begin
            led_r_n <= ~(lit[0] & enable);
            led_g_n <= ~(lit[1] & enable);
            led_b_n <= ~(lit[2] & enable);
            settled <= settled_next;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with PWM_BITS=8, RAMP_DIV=4, STEP=64.
// Time base: cyc counts rising edges since reset release; outputs sampled on the falling edge.
// Ramp ticks land on edges where cyc is a multiple of 4; active_duty reloads on edges 256, 512, ...
module tb_rgb_pwm_fader;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic red;
    logic green;
    logic blue;
    logic led_r_n;
    logic led_g_n;
    logic led_b_n;
    logic settled;

    int cyc;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int r_on_b    = 0;
    int r_on_c    = 0;
    int g_off_d   = 0;

    rgb_pwm_fader #(
        .PWM_BITS(8),
        .RAMP_DIV(4),
        .STEP    (64)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .led_r_n(led_r_n),
        .led_g_n(led_g_n),
        .led_b_n(led_b_n),
        .settled(settled)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Windowed tallies of LED behaviour over whole PWM periods.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc >= 513 && cyc <= 768 && led_r_n == 1'b0) r_on_b++;
            if (cyc >= 769 && cyc <= 1024 && led_r_n == 1'b0) r_on_c++;
            if (cyc >= 1095 && cyc <= 1111 && led_g_n == 1'b1) g_off_d++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        red    = 1'b0;
        green  = 1'b0;
        blue   = 1'b0;
        #23;
        chk("rst_led_r", led_r_n, 1);
        chk("rst_led_g", led_g_n, 1);
        chk("rst_led_b", led_b_n, 1);
        chk("rst_settled", settled, 1);
        chk("rst_duty_r", dut.duty[0], 0);
        chk("rst_pwm_cnt", dut.pwm_cnt, 0);

        // Red ramps up from zero.
        red = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        go_to(3);
        chk("a_duty_before_tick", dut.duty[0], 0);
        chk("a_settled_rising", settled, 0);
        go_to(4);
        chk("a_duty_64", dut.duty[0], 64);
        go_to(8);
        chk("a_duty_128", dut.duty[0], 128);
        go_to(12);
        chk("a_duty_192", dut.duty[0], 192);
        chk("a_settled_192", settled, 0);
        go_to(16);
        chk("a_duty_255", dut.duty[0], 255);
        chk("a_settled_255", settled, 1);
        chk("a_led_g", led_g_n, 1);
        chk("a_led_b", led_b_n, 1);
        chk("a_pwm_cnt", dut.pwm_cnt, 16);
        go_to(20);
        chk("a_duty_hold", dut.duty[0], 255);
        chk("a_active_not_yet", dut.active_duty[0], 0);
        chk("a_led_r_dark", led_r_n, 1);
        go_to(256);
        chk("a_active_loaded", dut.active_duty[0], 255);
        chk("a_led_r_still_dark", led_r_n, 1);
        go_to(257);
        chk("a_led_r_lit", led_r_n, 0);

        // Red ramps down.
        red = 1'b0;
        go_to(260);
        chk("b_duty_191", dut.duty[0], 191);
        go_to(264);
        chk("b_duty_127", dut.duty[0], 127);
        go_to(268);
        chk("b_duty_63", dut.duty[0], 63);
        chk("b_settled_63", settled, 0);
        go_to(272);
        chk("b_duty_0", dut.duty[0], 0);
        chk("b_settled_0", settled, 1);
        go_to(512);
        chk("b_led_r_last_lit", led_r_n, 0);
        go_to(513);
        chk("b_led_r_dark", led_r_n, 1);
        chk("b_active_0", dut.active_duty[0], 0);

        // Duty 64 captured at a boundary that coincides with a ramp tick.
        go_to(760);
        red = 1'b1;
        go_to(764);
        chk("c_duty_64", dut.duty[0], 64);
        go_to(768);
        chk("c_active_pre_tick", dut.active_duty[0], 64);
        chk("c_duty_post_tick", dut.duty[0], 128);
        red = 1'b0;
        go_to(772);
        chk("b_r_lit_cycles", r_on_b, 0);
        chk("c_reverse_64", dut.duty[0], 64);
        go_to(776);
        chk("c_down_0", dut.duty[0], 0);
        go_to(780);
        chk("c_no_underflow", dut.duty[0], 0);
        red = 1'b1;
        go_to(796);
        chk("c_up_255", dut.duty[0], 255);
        go_to(800);
        chk("c_no_wrap", dut.duty[0], 255);
        green = 1'b1;
        go_to(816);
        chk("d_duty_g_255", dut.duty[1], 255);
        go_to(832);
        chk("c_led_r_last_lit", led_r_n, 0);
        go_to(833);
        chk("c_led_r_first_dark", led_r_n, 1);
        go_to(1024);
        chk("d_led_g_dark", led_g_n, 1);
        go_to(1025);
        chk("c_r_lit_cycles", r_on_c, 64);
        chk("d_led_g_lit", led_g_n, 0);

        // Enable pulse low for 10 cycles while blue ramps.
        go_to(1100);
        chk("d_led_g_before", led_g_n, 0);
        enable = 1'b0;
        blue   = 1'b1;
        go_to(1101);
        chk("d_led_g_forced", led_g_n, 1);
        go_to(1108);
        chk("d_duty_b_ramps", dut.duty[2], 128);
        go_to(1110);
        chk("d_led_g_forced_end", led_g_n, 1);
        chk("d_pwm_cnt_runs", dut.pwm_cnt, 86);
        chk("d_duty_g_held", dut.duty[1], 255);
        enable = 1'b1;
        go_to(1111);
        chk("d_led_g_back", led_g_n, 0);

        // Asynchronous reset between edges with blue at 192.
        go_to(1112);
        chk("d_g_dark_cycles", g_off_d, 10);
        chk("e_duty_b_192", dut.duty[2], 192);
        #2;
        rst_n = 1'b0;
        #1;
        chk("e_led_r", led_r_n, 1);
        chk("e_led_g", led_g_n, 1);
        chk("e_led_b", led_b_n, 1);
        chk("e_settled", settled, 1);
        chk("e_duty_b", dut.duty[2], 0);
        chk("e_active_g", dut.active_duty[1], 0);
        chk("e_pwm_cnt", dut.pwm_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        go_to(3);
        chk("e_duty_b_restart", dut.duty[2], 0);
        go_to(4);
        chk("e_duty_b_64", dut.duty[2], 64);
        chk("e_duty_r_64", dut.duty[0], 64);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 Parameter PWM_BITS, default 8, SHALL set the PWM counter and duty width; MAX = 2^PWM_BITS-1.
REQ-002 Parameter RAMP_DIV, default 12000, SHALL set the number of clk cycles between duty updates (1 ms at 12 MHz).
REQ-003 Parameter STEP, default 4, SHALL set the duty change per ramp tick; legal range 1..MAX.
REQ-004 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  high = drive LEDs; low = force all LEDs dark.
REQ-007 red, green, blue  input  1 each  target colour levels from the upstream colour-cycling stage, synchronous to clk.
REQ-008 led_r_n, led_g_n, led_b_n  output  1 each  registered PWM LED drives, active-low (0 = lit).
REQ-009 settled  output  1  registered; high when every channel duty is at the extreme its target requests.

Function
REQ-010 Free-running PWM counter pwm_cnt (PWM_BITS) SHALL increment every cycle and wrap MAX->0.
REQ-011 Ramp counter SHALL count 0..RAMP_DIV-1 and wrap; ramp_tick SHALL be asserted for exactly the one cycle at RAMP_DIV-1.
REQ-012 Each channel SHALL hold a working duty register (PWM_BITS) and a shadow active_duty register.
REQ-013 On ramp_tick with target=1: duty <= min(duty+STEP, MAX), using PWM_BITS+1-bit arithmetic; no wrap permitted.
REQ-014 On ramp_tick with target=0: duty <= max(duty-STEP, 0); no underflow permitted.
REQ-015 Without ramp_tick, duty SHALL hold.
REQ-016 A target change mid-ramp SHALL reverse direction on the next ramp_tick from the current duty value, with no jump.
REQ-017 Per-channel state SHALL be one of OFF (duty=0, target=0), RISING (target=1, duty<MAX), ON (duty=MAX, target=1) or FALLING (target=0, duty>0).
REQ-018 The per-channel state SHALL be derived from target and duty only, and SHALL be reflected in settled.
REQ-019 active_duty SHALL load from duty only in the cycle where pwm_cnt==MAX, so a PWM period never mixes two duty values.
REQ-020 Channel lit condition: (active_duty==MAX) OR (pwm_cnt < active_duty); active_duty=0 SHALL give never lit.
REQ-021 led_x_n SHALL be registered as NOT(lit AND enable), one cycle after the pwm_cnt value that produced it.
REQ-022 enable low SHALL force all led_x_n=1 from the next cycle.
REQ-023 enable SHALL NOT stop pwm_cnt, the ramp counter or duty ramping.
REQ-024 settled SHALL register AND over channels of (target ? duty==MAX : duty==0), computed from post-update duty values.
REQ-025 A ramp_tick coinciding with pwm_cnt==MAX SHALL load the pre-tick duty into active_duty; the new duty applies one period later.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 While rst_n=0: pwm_cnt=0, ramp counter=0, all duty=0, all active_duty=0, led_r_n=led_g_n=led_b_n=1, settled=1.
REQ-028 Reset assertion mid-ramp SHALL clear state immediately, without waiting for clk.
REQ-029 After release, ramping SHALL restart from duty 0 on the first ramp_tick, RAMP_DIV cycles after the first clock edge.

Verification (bench parameters: PWM_BITS=8, RAMP_DIV=4, STEP=64)
REQ-030 red=1, green=blue=0, enable=1 after reset -> red duty 0,64,128,192,255 on successive ticks, then holds; settled 0 until duty=255, then 1; led_g_n=led_b_n=1 throughout.
REQ-031 red duty=255, then red=0 -> duty 191,127,63,0; led_r_n constantly 1 from the first full period after active_duty=0.
REQ-032 Active_duty=64 steady -> led_r_n=0 for exactly 64 of every 256 cycles; active_duty changes only at the pwm_cnt==MAX boundary.
REQ-033 Target toggled 1->0 at duty=128 -> next tick gives duty=64 (reversal without jump); the 1->0->1 sequence never wraps past 0 or 255.
REQ-034 enable=0 pulse for 10 cycles with green at duty=255 -> led_g_n=1 for exactly those 10 cycles (offset by one cycle); duty continues unaffected.
REQ-035 rst_n asserted asynchronously between clock edges at duty=192 -> all outputs take reset values immediately; after release, duty resumes from 0.
